ide_irq_latch: RTL and testbench
================================

// Module: ide_irq_latch
// PURPOSE
//  Upstream source of the INT2 input consumed by the INTREQR read-merge stage.
//  - Synchronises the IDE drive INTRQ and latches it as a pending interrupt.
//  - Drives INT2 active-low, so a CPU read of INTREQR reports PORTS (bit 3).
//  - Snoops 68030 bus cycles to clear or mask the pending interrupt the way
//    ATA and the Amiga expect.
// PARAMETERS
//  STATUS_ADDR    32'h00DA201C  IDE status register; a read clears pending
//  DEVCTL_ADDR    32'h00DA3018  IDE device control; a write updates nIEN/SRST
//  INTREQ_ADDR    32'h00DFF09C  Paula INTREQ; a write-clear of bit 3 clears pending
//  FILTER_CYCLES  4             consecutive stable clocks before INTRQ level accepted (>=1)
// PORTS
//  CLK          in   1   CPU-side clock, all logic on posedge
//  RESET        in   1   synchronous, active-low reset
//  A            in   32  68030 address bus
//  D            in   16  68030 data bus (IDE byte lane = D[15:8])
//  AS20         in   1   68030 address strobe, active low
//  RW20         in   1   1 = read, 0 = write
//  IDE_INTRQ    in   1   drive interrupt request, active high, asynchronous
//  INT2         out  1   registered, active low, to the INTREQR stage
//  IRQ_PENDING  out  1   registered pending latch, active high
//  NIEN         out  1   registered ATA nIEN mask, 1 = interrupt masked
// BEHAVIOUR
//  Reset (RESET==0 at a clock edge): INT2=1, IRQ_PENDING=0, NIEN=0; sync, filter and bus FSM are cleared.
//  Sync: two flops on IDE_INTRQ, reset value 0.
//  Edge: pending_set = 1 for exactly one clock on a 0->1 transition of the accepted level.
//  Bus FSM, states IDLE / DECODE / HOLD:
//   - IDLE -> DECODE when AS20==0. On that edge, latch the hit flags (full 32-bit compare) and RW20.
//   - DECODE -> HOLD unconditionally. While in DECODE, fire at most one event:
//     - read  & STATUS_ADDR: clr = 1
//     - write & DEVCTL_ADDR: NIEN <= D[9]; if D[10] (SRST) then clr = 1
//     - write & INTREQ_ADDR & D[15]==0 & D[3]==1: clr = 1
//     - INTREQ_ADDR with D[15]==1 (set request): ignored
//   - HOLD -> IDLE when AS20==1.
//   - AS20==1 seen while in DECODE: go to IDLE with no event (aborted cycle).
//   - Exactly one event per AS20 assertion, even if AS20 stays low for many clocks.
//  Pending update, evaluated every clock:
//   - set and clr in the same clock: set wins (a new interrupt is never lost).
//   - otherwise: set -> IRQ_PENDING=1; clr -> IRQ_PENDING=0; else hold.
//  INT2 <= ~(IRQ_PENDING & ~NIEN): registered, one clock after IRQ_PENDING/NIEN change.
//   - Setting NIEN=1 deasserts INT2 but keeps the latch; clearing NIEN re-asserts INT2 if still pending.
//  Latency:
//   - Without filter: IDE_INTRQ sampled high at edge k gives IRQ_PENDING=1 at k+3 and INT2=0 at k+4.
//   - With filter: add FILTER_CYCLES.
//   - A level that stays high after a clear does not re-set pending; only a fresh 0->1 edge does.
// CONFIGURATION
//  Macro IDE_IRQ_FILTER_EN
//   - Defined: accepted level changes only after the synced level has differed from it for
//     FILTER_CYCLES consecutive clocks. Counter width $clog2(FILTER_CYCLES+1); it resets to 0
//     whenever the synced level equals the accepted level.
//   - Undefined: accepted level = second sync flop; FILTER_CYCLES is unused.
// STRUCTURE
//  Shared package tf_ide_pkg:
//   - register address constants (STATUS/DEVCTL/INTREQ)
//   - bus FSM state encoding (IDLE=2'd0, DECODE=2'd1, HOLD=2'd2)
//   - DEVCTL bit positions (NIEN_BIT=9, SRST_BIT=10)
//  Sub-module irq_sync_filter: synchroniser plus optional filter; outputs the accepted level
//  and the pending_set pulse. Bus FSM and pending latch stay in ide_irq_latch.
// TESTING
//  1. Reset with IDE_INTRQ=1 held: INT2=1, IRQ_PENDING=0 during reset; after release,
//     the level already high gives no edge, so INT2 stays 1.
//  2. Filter off, IDE_INTRQ 0->1 sampled at edge 10: IRQ_PENDING=1 at edge 13, INT2=0 at 14.
//     Filter on: at 17 / 18.
//  3. Read of 0x00DA201C (AS20 low 6 clocks): IRQ_PENDING clears once, one clock after AS20 is
//     sampled low; INT2=1 on the next clock; no second clear.
//  4. Write 0x00DA3018, D=16'h0200: NIEN=1, INT2=1, IRQ_PENDING stays 1. Write D=16'h0000:
//     INT2=0 again. Write D=16'h0400: IRQ_PENDING=0.
//  5. Write 0x00DFF09C: D=16'h0008 clears pending; D=16'h8008 has no effect. The clear coincides
//     with a new pending_set: IRQ_PENDING stays 1.
//  6. IDE_INTRQ glitch 2 clocks wide with the filter on (FILTER_CYCLES=4): no pending.
//     AS20 pulse of 1 clock on a status read (aborted in DECODE): no clear.

Source files
------------

// File: rtl/tf_ide_pkg.sv
// Shared definitions for the IDE interrupt latch: snooped register
// addresses, the bus-snoop FSM encoding and the DEVCTL/INTREQ bit positions.
package tf_ide_pkg;

    localparam logic [31:0] REG_STATUS_ADDR = 32'h00DA_201C;
    localparam logic [31:0] REG_DEVCTL_ADDR = 32'h00DA_3018;
    localparam logic [31:0] REG_INTREQ_ADDR = 32'h00DF_F09C;

    // DEVCTL bits as they appear on D[15:8] (IDE byte lane)
    localparam int NIEN_BIT = 9;
    localparam int SRST_BIT = 10;

    // Paula INTREQ: bit 15 selects set (1) or clear (0), bit 3 is PORTS
    localparam int INTREQ_SETCLR_BIT = 15;
    localparam int INTREQ_PORTS_BIT  = 3;

    typedef enum logic [1:0] {
        BUS_IDLE   = 2'd0,
        BUS_DECODE = 2'd1,
        BUS_HOLD   = 2'd2
    } bus_state_e;

endpackage

// File: rtl/irq_sync_filter.sv
// Synchroniser for the asynchronous IDE INTRQ line, optional stability
// filter (macro IDE_IRQ_FILTER_EN) and rising-edge detector producing a
// one-clock pending-set pulse. The detector stays disarmed until a real
// low level has been seen after reset, so a line that is already high
// when reset releases never produces an interrupt.
module irq_sync_filter
`ifdef IDE_IRQ_FILTER_EN
#(
    parameter int unsigned FILTER_CYCLES = 4
)
`endif
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic irq_i,
    output logic set_o
);

    logic sync1_q, sync2_q;
    logic vld1_q, vld2_q;
    logic level;
    logic prev_q;
    logic armed_q;
    logic set_q;

    // Two-flop synchroniser plus a matching valid pipe marking real samples
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
            vld1_q  <= 1'b1;
            vld2_q  <= vld1_q;
        end
    end

`ifdef IDE_IRQ_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc_q, acc_d;

    // Accept a new level only after it has persisted FILTER_CYCLES clocks
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (sync2_q == acc_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            acc_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Filter state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            acc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    assign level = acc_q;
`else
    assign level = sync2_q;
`endif

    // Edge detector: registered pulse on a 0->1 of the accepted level once armed
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            set_q   <= 1'b0;
        end else begin
            prev_q  <= level;
            armed_q <= armed_q | (vld2_q & ~sync2_q & ~level);
            set_q   <= armed_q & level & ~prev_q;
        end
    end

    assign set_o = set_q;

endmodule

// File: rtl/ide_irq_latch.sv
// IDE interrupt latch feeding INT2 (active low) to the INTREQR merge stage.
// Snoops 68030 bus cycles: a STATUS read, an SRST write to DEVCTL or a
// PORTS write-clear to Paula INTREQ clears the pending latch; DEVCTL writes
// also update the nIEN mask. A new interrupt in the same clock as a clear
// wins. Optional INTRQ stability filter: macro IDE_IRQ_FILTER_EN.
//
// Bus handshake: a cycle starts when AS20 is sampled low in IDLE (address
// and RW20 captured), the single event fires on the following clock if
// AS20 is still low (data sampled then), and the FSM waits in HOLD until
// AS20 returns high. AS20 high in DECODE aborts the cycle with no event.
module ide_irq_latch
    import tf_ide_pkg::*;
#(
    parameter logic [31:0] STATUS_ADDR = REG_STATUS_ADDR,
    parameter logic [31:0] DEVCTL_ADDR = REG_DEVCTL_ADDR,
    parameter logic [31:0] INTREQ_ADDR = REG_INTREQ_ADDR
`ifdef IDE_IRQ_FILTER_EN
    ,
    parameter int unsigned FILTER_CYCLES = 4
`endif
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] A,
    input  logic [15:0] D,
    input  logic        AS20,
    input  logic        RW20,
    input  logic        IDE_INTRQ,
    output logic        INT2,
    output logic        IRQ_PENDING,
    output logic        NIEN
);

    bus_state_e state_q, state_d;
    logic hit_status_q, hit_status_d;
    logic hit_devctl_q, hit_devctl_d;
    logic hit_intreq_q, hit_intreq_d;
    logic rd_q, rd_d;
    logic nien_q, nien_d;
    logic pend_q, pend_d;
    logic int2_q, int2_d;
    logic clr;
    logic pending_set;

    // Data bits that carry no meaning for this block
    logic unused_d_bits;
    assign unused_d_bits = ^{D[14:11], D[8:4], D[2:0]};

`ifdef IDE_IRQ_FILTER_EN
    irq_sync_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_sync (
`else
    irq_sync_filter u_sync (
`endif
        .clk_i (CLK),
        .rst_ni(RESET),
        .irq_i (IDE_INTRQ),
        .set_o (pending_set)
    );

    // Bus-snoop next state, one event per AS20 assertion, pending/mask update
    always_comb begin
        state_d      = state_q;
        hit_status_d = hit_status_q;
        hit_devctl_d = hit_devctl_q;
        hit_intreq_d = hit_intreq_q;
        rd_d         = rd_q;
        nien_d       = nien_q;
        clr          = 1'b0;
        unique case (state_q)
            BUS_IDLE: begin
                if (!AS20) begin
                    state_d      = BUS_DECODE;
                    hit_status_d = (A == STATUS_ADDR);
                    hit_devctl_d = (A == DEVCTL_ADDR);
                    hit_intreq_d = (A == INTREQ_ADDR);
                    rd_d         = RW20;
                end
            end
            BUS_DECODE: begin
                if (AS20) begin
                    state_d = BUS_IDLE;
                end else begin
                    state_d = BUS_HOLD;
                    if (rd_q && hit_status_q) begin
                        clr = 1'b1;
                    end else if (!rd_q && hit_devctl_q) begin
                        nien_d = D[NIEN_BIT];
                        clr    = D[SRST_BIT];
                    end else if (!rd_q && hit_intreq_q) begin
                        clr = ~D[INTREQ_SETCLR_BIT] & D[INTREQ_PORTS_BIT];
                    end
                end
            end
            BUS_HOLD: begin
                if (AS20) begin
                    state_d = BUS_IDLE;
                end
            end
            default: state_d = BUS_IDLE;
        endcase

        if (pending_set) begin
            pend_d = 1'b1;
        end else if (clr) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        int2_d = ~(pend_q & ~nien_q);
    end

    // State, latch, mask and INT2 registers
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= BUS_IDLE;
            hit_status_q <= 1'b0;
            hit_devctl_q <= 1'b0;
            hit_intreq_q <= 1'b0;
            rd_q         <= 1'b0;
            nien_q       <= 1'b0;
            pend_q       <= 1'b0;
            int2_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            hit_status_q <= hit_status_d;
            hit_devctl_q <= hit_devctl_d;
            hit_intreq_q <= hit_intreq_d;
            rd_q         <= rd_d;
            nien_q       <= nien_d;
            pend_q       <= pend_d;
            int2_q       <= int2_d;
        end
    end

    assign INT2        = int2_q;
    assign IRQ_PENDING = pend_q;
    assign NIEN        = nien_q;

endmodule

// File: tb/tb_ide_irq_latch.sv
// Bench for ide_irq_latch: directed scenarios plus randomized bus/INTRQ
// traffic checked against a history-based reference model.
module tb_ide_irq_latch;

    localparam logic [31:0] STATUS_A = 32'h00DA_201C;
    localparam logic [31:0] DEVCTL_A = 32'h00DA_3018;
    localparam logic [31:0] INTREQ_A = 32'h00DF_F09C;
`ifdef IDE_IRQ_FILTER_EN
    localparam int F = 4;
`else
    localparam int F = 0;
`endif
    localparam int MAXE = 16384;
    localparam int BIG  = 1 << 30;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] A;
    logic [15:0] D;
    logic        AS20;
    logic        RW20;
    logic        IDE_INTRQ;
    logic        INT2;
    logic        IRQ_PENDING;
    logic        NIEN;

    int vectors = 0;
    int miscompares = 0;

    ide_irq_latch dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .A          (A),
        .D          (D),
        .AS20       (AS20),
        .RW20       (RW20),
        .IDE_INTRQ  (IDE_INTRQ),
        .INT2       (INT2),
        .IRQ_PENDING(IRQ_PENDING),
        .NIEN       (NIEN)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    // Index i = i-th clock edge after reset release. Synced level after
    // edge i is the raw sample from edge i-1; the accepted level follows
    // the synced level once it has differed for F consecutive edges.
    bit          raw_h[MAXE];
    bit          syn_h[MAXE];
    bit          acc_h[MAXE];
    bit          as_h[MAXE];
    bit          rw_h[MAXE];
    logic [31:0] a_h[MAXE];
    int          ne = 0;
    int          first_arm = BIG;
    bit          m_pend = 1'b0;
    bit          m_nien = 1'b0;
    bit          m_int2 = 1'b1;

    function automatic bit acc_at(int i);
        return (i < 0) ? 1'b0 : acc_h[i];
    endfunction

    function automatic bit syn_at(int i);
        return (i < 1) ? 1'b0 : syn_h[i];
    endfunction

    always @(posedge CLK) begin
        if (RESET !== 1'b1) begin
            ne        = 0;
            first_arm = BIG;
            m_pend    = 1'b0;
            m_nien    = 1'b0;
            m_int2    = 1'b1;
        end else begin : model_step
            bit acc_prev, acc, run, set_ev, clr_ev, ev, rd, nien_n;
            logic [31:0] addr;
            raw_h[ne] = IDE_INTRQ;
            as_h[ne]  = AS20;
            rw_h[ne]  = RW20;
            a_h[ne]   = A;
            syn_h[ne] = (ne >= 1) ? raw_h[ne-1] : 1'b0;
            acc_prev  = acc_at(ne - 1);
            if (F == 0) begin
                acc = syn_h[ne];
            end else begin
                run = 1'b1;
                for (int j = 1; j <= F; j++)
                    if (syn_at(ne - j) == acc_prev) run = 1'b0;
                acc = run ? ~acc_prev : acc_prev;
            end
            acc_h[ne] = acc;
            if (first_arm == BIG && ne >= 1 && !syn_h[ne] && !acc) first_arm = ne;
            // rising accepted level reaches the latch two edges later
            set_ev = (ne >= 3) && acc_at(ne - 2) && !acc_at(ne - 3) && (first_arm <= ne - 3);
            // event: second consecutive low AS20 sample following a high one
            ev = (ne >= 1) && !as_h[ne] && !as_h[ne-1] && (ne < 2 || as_h[ne-2]);
            clr_ev = 1'b0;
            nien_n = m_nien;
            if (ev) begin
                addr = a_h[ne-1];
                rd   = rw_h[ne-1];
                if (rd && addr == STATUS_A) clr_ev = 1'b1;
                if (!rd && addr == DEVCTL_A) begin
                    nien_n = D[9];
                    if (D[10]) clr_ev = 1'b1;
                end
                if (!rd && addr == INTREQ_A && !D[15] && D[3]) clr_ev = 1'b1;
            end
            m_int2 = ~(m_pend & ~m_nien);
            m_pend = set_ev ? 1'b1 : (clr_ev ? 1'b0 : m_pend);
            m_nien = nien_n;
            ne++;
        end
    end

    // ---------------- driver tasks (called just after a negedge) ----------------
    task automatic bus_cycle(input logic [31:0] addr, input logic rw,
                             input logic [15:0] data, input int n_low);
        A = addr; RW20 = rw; D = data; AS20 = 1'b0;
        repeat (n_low) @(negedge CLK);
        AS20 = 1'b1; RW20 = 1'b1; D = 16'h0000;
        repeat (2) @(negedge CLK);
    endtask

    task automatic make_irq();
        IDE_INTRQ = 1'b0;
        repeat (6 + F) @(negedge CLK);
        IDE_INTRQ = 1'b1;
        repeat (6 + F) @(negedge CLK);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESET = 1'b0; IDE_INTRQ = 1'b1; AS20 = 1'b1; RW20 = 1'b1;
        A = 32'h0; D = 16'h0;
        repeat (3) @(negedge CLK);
        vectors++;
        if (INT2 !== 1'b1) begin miscompares++; $display("FAIL reset_int2: got %b expected 1", INT2); end
        vectors++;
        if (IRQ_PENDING !== 1'b0) begin miscompares++; $display("FAIL reset_pending: got %b expected 0", IRQ_PENDING); end
        vectors++;
        if (NIEN !== 1'b0) begin miscompares++; $display("FAIL reset_nien: got %b expected 0", NIEN); end
        RESET = 1'b1;
        for (int c = 0; c < 10 + F; c++) begin
            @(negedge CLK);
            vectors++;
            if (INT2 !== 1'b1 || IRQ_PENDING !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_high_level c=%0d: got int2=%b pend=%b expected int2=1 pend=0", c, INT2, IRQ_PENDING);
            end
        end
    endtask

    task automatic test_latency();
        IDE_INTRQ = 1'b0;
        repeat (8 + F) @(negedge CLK);
        vectors++;
        if (IRQ_PENDING !== 1'b0) begin miscompares++; $display("FAIL latency_idle: got %b expected 0", IRQ_PENDING); end
        IDE_INTRQ = 1'b1;  // sampled high at the next edge k
        for (int c = 0; c <= 4 + F; c++) begin
            bit exp_p, exp_i;
            @(negedge CLK);  // after edge k+c
            exp_p = (c >= 3 + F);
            exp_i = !(c >= 4 + F);
            vectors++;
            if (IRQ_PENDING !== exp_p) begin miscompares++; $display("FAIL latency_pending k+%0d: got %b expected %b", c, IRQ_PENDING, exp_p); end
            vectors++;
            if (INT2 !== exp_i) begin miscompares++; $display("FAIL latency_int2 k+%0d: got %b expected %b", c, INT2, exp_i); end
        end
    endtask

    task automatic test_status_read();
        A = STATUS_A; RW20 = 1'b1; AS20 = 1'b0;  // sampled low at edge e
        for (int c = 0; c < 6; c++) begin
            bit exp_p, exp_i;
            @(negedge CLK);  // after edge e+c
            exp_p = (c == 0);
            exp_i = (c >= 2);
            vectors++;
            if (IRQ_PENDING !== exp_p) begin miscompares++; $display("FAIL status_pending e+%0d: got %b expected %b", c, IRQ_PENDING, exp_p); end
            vectors++;
            if (INT2 !== exp_i) begin miscompares++; $display("FAIL status_int2 e+%0d: got %b expected %b", c, INT2, exp_i); end
        end
        AS20 = 1'b1;
        repeat (4) @(negedge CLK);
        vectors++;
        if (IRQ_PENDING !== 1'b0 || INT2 !== 1'b1) begin
            miscompares++;
            $display("FAIL status_after: got pend=%b int2=%b expected pend=0 int2=1", IRQ_PENDING, INT2);
        end
    endtask

    task automatic test_devctl();
        make_irq();
        vectors++;
        if (IRQ_PENDING !== 1'b1 || INT2 !== 1'b0) begin
            miscompares++; $display("FAIL devctl_setup: got pend=%b int2=%b expected pend=1 int2=0", IRQ_PENDING, INT2);
        end
        bus_cycle(DEVCTL_A, 1'b0, 16'h0200, 3);
        vectors++;
        if (NIEN !== 1'b1 || INT2 !== 1'b1 || IRQ_PENDING !== 1'b1) begin
            miscompares++; $display("FAIL devctl_mask: got nien=%b int2=%b pend=%b expected 1 1 1", NIEN, INT2, IRQ_PENDING);
        end
        bus_cycle(DEVCTL_A, 1'b0, 16'h0000, 3);
        vectors++;
        if (NIEN !== 1'b0 || INT2 !== 1'b0 || IRQ_PENDING !== 1'b1) begin
            miscompares++; $display("FAIL devctl_unmask: got nien=%b int2=%b pend=%b expected 0 0 1", NIEN, INT2, IRQ_PENDING);
        end
        bus_cycle(DEVCTL_A, 1'b0, 16'h0400, 3);
        vectors++;
        if (NIEN !== 1'b0 || INT2 !== 1'b1 || IRQ_PENDING !== 1'b0) begin
            miscompares++; $display("FAIL devctl_srst: got nien=%b int2=%b pend=%b expected 0 1 0", NIEN, INT2, IRQ_PENDING);
        end
    endtask

    task automatic test_intreq();
        make_irq();
        bus_cycle(INTREQ_A, 1'b0, 16'h0008, 3);
        vectors++;
        if (IRQ_PENDING !== 1'b0 || INT2 !== 1'b1) begin
            miscompares++; $display("FAIL intreq_clear: got pend=%b int2=%b expected pend=0 int2=1", IRQ_PENDING, INT2);
        end
        make_irq();
        bus_cycle(INTREQ_A, 1'b0, 16'h8008, 3);
        vectors++;
        if (IRQ_PENDING !== 1'b1 || INT2 !== 1'b0) begin
            miscompares++; $display("FAIL intreq_set_ignored: got pend=%b int2=%b expected pend=1 int2=0", IRQ_PENDING, INT2);
        end
        bus_cycle(STATUS_A, 1'b1, 16'h0000, 2);
        vectors++;
        if (IRQ_PENDING !== 1'b0) begin miscompares++; $display("FAIL intreq_preclear: got %b expected 0", IRQ_PENDING); end
        // line low, then a rise timed so the set lands on the clear edge
        IDE_INTRQ = 1'b0;
        repeat (6 + F) @(negedge CLK);
        IDE_INTRQ = 1'b1;             // edge k
        repeat (2 + F) @(negedge CLK);
        bus_cycle(INTREQ_A, 1'b0, 16'h0008, 3);  // event at edge k+3+F
        vectors++;
        if (IRQ_PENDING !== 1'b1) begin miscompares++; $display("FAIL intreq_set_wins: got %b expected 1", IRQ_PENDING); end
    endtask

    task automatic test_glitch_abort();
        bit exp_p;
        bus_cycle(STATUS_A, 1'b1, 16'h0000, 2);
        IDE_INTRQ = 1'b0;
        repeat (6 + F) @(negedge CLK);
        IDE_INTRQ = 1'b1;
        repeat (2) @(negedge CLK);
        IDE_INTRQ = 1'b0;
        repeat (8 + F) @(negedge CLK);
        exp_p = (F <= 2);
        vectors++;
        if (IRQ_PENDING !== exp_p) begin miscompares++; $display("FAIL glitch_pending: got %b expected %b", IRQ_PENDING, exp_p); end
        make_irq();
        bus_cycle(STATUS_A, 1'b1, 16'h0000, 1);
        vectors++;
        if (IRQ_PENDING !== 1'b1) begin miscompares++; $display("FAIL aborted_read: got %b expected 1", IRQ_PENDING); end
    endtask

    task automatic test_back_to_back();
        A = DEVCTL_A; RW20 = 1'b0; D = 16'h0200; AS20 = 1'b0;  // edges e, e+1 low
        repeat (2) @(negedge CLK);
        vectors++;
        if (NIEN !== 1'b1) begin miscompares++; $display("FAIL b2b_first: got %b expected 1", NIEN); end
        AS20 = 1'b1;                                            // edge e+2 high
        @(negedge CLK);
        D = 16'h0000; AS20 = 1'b0;                              // edges e+3, e+4 low
        repeat (2) @(negedge CLK);
        vectors++;
        if (NIEN !== 1'b0) begin miscompares++; $display("FAIL b2b_second: got %b expected 0", NIEN); end
        AS20 = 1'b1; RW20 = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_random(input int cycles);
        logic [31:0] addrs[4];
        addrs[0] = STATUS_A; addrs[1] = DEVCTL_A; addrs[2] = INTREQ_A; addrs[3] = 32'h00DA_2000;
        for (int c = 0; c < cycles; c++) begin
            @(negedge CLK);
            vectors++;
            if (IRQ_PENDING !== m_pend) begin miscompares++; $display("FAIL rand_pending c=%0d: got %b expected %b", c, IRQ_PENDING, m_pend); end
            vectors++;
            if (INT2 !== m_int2) begin miscompares++; $display("FAIL rand_int2 c=%0d: got %b expected %b", c, INT2, m_int2); end
            vectors++;
            if (NIEN !== m_nien) begin miscompares++; $display("FAIL rand_nien c=%0d: got %b expected %b", c, NIEN, m_nien); end
            if ($urandom_range(0, 7) == 0) IDE_INTRQ = ~IDE_INTRQ;
            if ($urandom_range(0, 2) == 0) begin
                AS20 = ~AS20;
                if (!AS20) begin
                    A    = addrs[$urandom_range(0, 3)];
                    RW20 = $urandom_range(0, 1) == 1;
                end
            end
            D = 16'($urandom);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_latency();
        test_status_read();
        test_devctl();
        test_intreq();
        test_glitch_abort();
        test_back_to_back();
        test_random(1500);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
